mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store initiator sitting between the CPU MEM stage and the data `memory` block. Accepts one load/store request at a time and checks alignment. Drives the memory's ce/we/addr/data/byte-select port for a parameterisable number of wait cycles, then returns sign/zero-extended load data. Stalls the pipeline for the duration of the access.

## Interface
- `WAIT_CYCLES`, default 0: extra cycles the memory port is held before read data is sampled; legal range 0–15.
- `clk` in 1: system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when `rst == 0`).
- `req_i` in 1: MEM stage holds a valid load/store; must stay stable, with its operands, while `stall_o` is high.
- `op_i` in 3: `MemOp` code: LB, LBU, LH, LHU, LW, SB, SH, SW.
- `addr_i` in `MemAddrWidth`: byte address.
- `wdata_i` in `MemDataWidth`: store data, right-aligned.
- `stall_o` out 1: pipeline stall request.
- `done_o` out 1: one-cycle pulse; the access has completed.
- `rdata_o` out `MemDataWidth`: extended load result; holds until the next load completes.
- `misalign_o` out 1: one-cycle exception pulse.
- `badaddr_o` out `MemAddrWidth`: faulting address, valid with `misalign_o` and held afterwards.
- `mem_ce_o` out 1, `mem_we_o` out 1, `mem_addr_o` out `MemAddrWidth`, `mem_data_o` out `MemDataWidth`, `mem_byte_slct_o` out `ByteSlctWidth`: memory port.
- `mem_data_i` in `MemDataWidth`: memory read data.

## Operation
- FSM states and transitions:
  - IDLE: `req_i` with an aligned address captures op, addr and wdata, loads `wcnt = WAIT_CYCLES`, then goes to ACCESS. `req_i` with a misaligned address starts no memory access; it gives `misalign_o = 1` and `badaddr_o = addr_i` next cycle and stays IDLE.
  - ACCESS: drives the memory port. If `wcnt != 0`, decrement. If `wcnt == 0`, sample `mem_data_i` into `rdata_o` (loads only) and go to DONE.
  - DONE: `done_o = 1` for this cycle, then go to IDLE. `req_i` is ignored in DONE.
- Misalignment rules:
  - LH/LHU/SH are misaligned when `addr[0] = 1`.
  - LW/SW are misaligned when `addr[1:0] != 0`.
  - Byte ops are never misaligned.
- Memory port in ACCESS; all memory outputs are 0 outside ACCESS:
  - `mem_ce_o = 1`; `mem_addr_o = {addr[31:2], 2'b00}`; `mem_we_o = 1` for stores only.
- Lane mapping is big-endian: offset 0 maps to `[31:24]`.
  - SB: `byte_slct = 4'b1000 >> off`, data `{4{b}}`.
  - SH: `byte_slct = 1100` for off 0, `0011` for off 2; data `{2{h}}`.
  - SW: `byte_slct = 1111`.
  - Loads: `byte_slct = 0000`.
- Load extraction selects the lane by offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `stall_o = (IDLE & req_i & aligned) | ACCESS`. It is low in DONE and on a misaligned request.
- Memory outputs depend only on state and captured registers, never combinationally on `req_i`.

## Timing
- Request sampled in cycle T. ACCESS spans T+1 … T+1+WAIT_CYCLES. `done_o` and updated `rdata_o` appear at T+2+WAIT_CYCLES.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE. Minimum spacing is 3+WAIT_CYCLES cycles.
- A misaligned request in cycle T gives `misalign_o` at T+1. A new request may be accepted at T+1.
- Reset values: state IDLE; every output 0, including `rdata_o` and `badaddr_o`.
- Reset asserted mid-ACCESS:
  - `mem_ce_o`/`mem_we_o` drop immediately (asynchronously).
  - The access is abandoned and no `done_o` follows.
  - A store may be partially committed by the memory; this is accepted.
- The `wcnt` counter is 4 bits and never wraps, because it is reloaded only in IDLE.

## Structure
- Shared definitions file carries:
  - `MemOp` encodings `MemOpLB`…`MemOpSW`.
  - Existing `MemDataWidth`, `MemAddrWidth`, `ByteSlctWidth`, `ZeroWord`, `ChipEnable`, `WriteEnable`.
- FSM state encoding stays local.
- One combinational sub-module `mem_lane_align` does store lane steering and byte-select generation, plus load extraction and extension.

## Test plan
- Reset: `rst = 0` mid-ACCESS of SW → `mem_ce_o = 0`, `mem_we_o = 0` immediately; all outputs 0; after release, no `done_o` pulse.
- SW → LW round trip: SW `addr = 0x10`, `wdata = 0xDEADBEEF` → `byte_slct = 1111`, `mem_addr_o = 0x10`. Then LW 0x10 → `rdata_o = 0xDEADBEEF`, with `done_o` at T+2 (WAIT_CYCLES = 0).
- Byte lanes: SB `addr = 0x13`, `wdata = 0x000000A5` → `byte_slct = 0001`, `mem_data_o = 0xA5A5A5A5`. Then LB 0x13 → `0xFFFFFFA5`; LBU 0x13 → `0x000000A5`.
- Halfwords: word at 0x20 holds `0x8001_7FFE`. LH 0x20 → `0xFFFF8001`; LHU 0x20 → `0x00008001`; LH 0x22 → `0x00007FFE`.
- Misalignment: LW `0x21` → `misalign_o` pulse at T+1, `badaddr_o = 0x21`, `mem_ce_o` never high, `stall_o` low. SH `0x23` → same behaviour.
- Wait states: with `WAIT_CYCLES = 3`, LW → `stall_o` high for 5 cycles, `mem_ce_o` high for exactly 4 cycles, `done_o` at T+5; `req_i` held high during DONE starts no second access.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store initiator: widths, memory op codes
// and small decode helpers used by the controller and its lane aligner.
package mem_access_ctrl_pkg;

    localparam int MemDataWidth  = 32;
    localparam int MemAddrWidth  = 32;
    localparam int ByteSlctWidth = 4;

    localparam logic [MemDataWidth-1:0] ZeroWord    = 32'h0000_0000;
    localparam logic                    ChipEnable  = 1'b1;
    localparam logic                    WriteEnable = 1'b1;

    typedef enum logic [2:0] {
        MemOpLB  = 3'd0,
        MemOpLBU = 3'd1,
        MemOpLH  = 3'd2,
        MemOpLHU = 3'd3,
        MemOpLW  = 3'd4,
        MemOpSB  = 3'd5,
        MemOpSH  = 3'd6,
        MemOpSW  = 3'd7
    } mem_op_e;

    function automatic logic is_store(input mem_op_e op);
        case (op)
            MemOpSB, MemOpSH, MemOpSW: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_aligned(input mem_op_e op, input logic [1:0] off);
        case (op)
            MemOpLH, MemOpLHU, MemOpSH: return (off[0] == 1'b0);
            MemOpLW, MemOpSW:           return (off == 2'b00);
            default:                    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: store data replication / byte selects, and
// load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  mem_op_e                  op,
    input  logic [1:0]               off,
    input  logic [MemDataWidth-1:0]  wdata,
    input  logic [MemDataWidth-1:0]  rword,
    output logic [ByteSlctWidth-1:0] byte_slct,
    output logic [MemDataWidth-1:0]  store_data,
    output logic [MemDataWidth-1:0]  load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: offset 0 is the most significant lane.
    always_comb begin
        byte_slct  = 4'b0000;
        store_data = ZeroWord;
        case (op)
            MemOpSB: begin
                byte_slct  = 4'b1000 >> off;
                store_data = {4{wdata[7:0]}};
            end
            MemOpSH: begin
                byte_slct  = off[1] ? 4'b0011 : 4'b1100;
                store_data = {2{wdata[15:0]}};
            end
            MemOpSW: begin
                byte_slct  = 4'b1111;
                store_data = wdata;
            end
            default: begin
                byte_slct  = 4'b0000;
                store_data = ZeroWord;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the read word.
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = rword[31:24];
            2'd1:    byte_s = rword[23:16];
            2'd2:    byte_s = rword[15:8];
            2'd3:    byte_s = rword[7:0];
            default: byte_s = 8'h00;
        endcase
        half_s = off[1] ? rword[15:0] : rword[31:16];
    end

    // Extend the selected lane to a full word.
    always_comb begin
        load_data = ZeroWord;
        case (op)
            MemOpLB:  load_data = {{24{byte_s[7]}}, byte_s};
            MemOpLBU: load_data = {24'h00_0000, byte_s};
            MemOpLH:  load_data = {{16{half_s[15]}}, half_s};
            MemOpLHU: load_data = {16'h0000, half_s};
            MemOpLW:  load_data = rword;
            default:  load_data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and the data memory: checks
// alignment, holds the memory port for WAIT_CYCLES extra cycles, stalls the pipe.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [2:0]               op_i,
    input  logic [MemAddrWidth-1:0]  addr_i,
    input  logic [MemDataWidth-1:0]  wdata_i,
    output logic                     stall_o,
    output logic                     done_o,
    output logic [MemDataWidth-1:0]  rdata_o,
    output logic                     misalign_o,
    output logic [MemAddrWidth-1:0]  badaddr_o,
    output logic                     mem_ce_o,
    output logic                     mem_we_o,
    output logic [MemAddrWidth-1:0]  mem_addr_o,
    output logic [MemDataWidth-1:0]  mem_data_o,
    output logic [ByteSlctWidth-1:0] mem_byte_slct_o,
    input  logic [MemDataWidth-1:0]  mem_data_i
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_e                    state_r, state_s;
    mem_op_e                   op_r;
    logic [MemAddrWidth-1:0]   addr_r;
    logic [MemDataWidth-1:0]   wdata_r;
    logic [3:0]                wcnt_r;
    logic [MemDataWidth-1:0]   rdata_r;
    logic                      misalign_r;
    logic [MemAddrWidth-1:0]   badaddr_r;

    mem_op_e                   op_in_s;
    logic                      aligned_s, accept_s, fault_s, last_s, access_s;
    logic [ByteSlctWidth-1:0]  slct_s;
    logic [MemDataWidth-1:0]   store_data_s, load_data_s;

    assign op_in_s   = mem_op_e'(op_i);
    assign aligned_s = is_aligned(op_in_s, addr_i[1:0]);
    assign last_s    = (wcnt_r == 4'd0);
    assign access_s  = (state_r == StAccess);

    // Next-state decode; DONE deliberately ignores req_i.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        fault_s  = 1'b0;
        case (state_r)
            StIdle: begin
                if (req_i && aligned_s) begin
                    accept_s = 1'b1;
                    state_s  = StAccess;
                end else if (req_i) begin
                    fault_s  = 1'b1;
                    state_s  = StIdle;
                end else begin
                    state_s  = StIdle;
                end
            end
            StAccess: begin
                if (last_s) begin
                    state_s = StDone;
                end else begin
                    state_s = StAccess;
                end
            end
            StDone:  state_s = StIdle;
            default: state_s = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= StIdle;
        end else begin
            state_r <= state_s;
        end
    end

    // Request capture and wait-state countdown; reloaded only on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r    <= MemOpLB;
            addr_r  <= '0;
            wdata_r <= ZeroWord;
            wcnt_r  <= 4'd0;
        end else if (accept_s) begin
            op_r    <= op_in_s;
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
            wcnt_r  <= WaitInit;
        end else if (access_s && !last_s) begin
            wcnt_r  <= wcnt_r - 4'd1;
        end else begin
            wcnt_r  <= wcnt_r;
        end
    end

    // Load result and misalignment exception registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r    <= ZeroWord;
            misalign_r <= 1'b0;
            badaddr_r  <= '0;
        end else begin
            misalign_r <= fault_s;
            if (access_s && last_s && !is_store(op_r)) begin
                rdata_r <= load_data_s;
            end
            if (fault_s) begin
                badaddr_r <= addr_i;
            end
        end
    end

    mem_lane_align u_lane (
        .op         (op_r),
        .off        (addr_r[1:0]),
        .wdata      (wdata_r),
        .rword      (mem_data_i),
        .byte_slct  (slct_s),
        .store_data (store_data_s),
        .load_data  (load_data_s)
    );

    // Memory port is decoded from state and captured registers only, so it
    // falls to zero the moment reset clears the state register.
    assign mem_ce_o        = access_s ? ChipEnable : 1'b0;
    assign mem_we_o        = (access_s && is_store(op_r)) ? WriteEnable : 1'b0;
    assign mem_addr_o      = access_s ? {addr_r[MemAddrWidth-1:2], 2'b00} : '0;
    assign mem_data_o      = access_s ? store_data_s : ZeroWord;
    assign mem_byte_slct_o = access_s ? slct_s : 4'b0000;

    assign stall_o    = accept_s | access_s;
    assign done_o     = (state_r == StDone);
    assign rdata_o    = rdata_r;
    assign misalign_o = misalign_r;
    assign badaddr_o  = badaddr_r;

endmodule
